// File: rtl/l2_cache_meta_walker_pkg.sv
// Shared L2 geometry and metadata types used by the L2 metadata walker.
package l2_cache_meta_walker_pkg;

  localparam int L2_WAYS         = 4;
  localparam int L2_SETS         = 256;
  localparam int L2_SET_W        = $clog2(L2_SETS);
  localparam int L2_TAG_W        = 20;
  localparam int ERR_QUEUE_DEPTH = 4;

  typedef logic [L2_SET_W-1:0] l2_set_idx_t;
  typedef logic [L2_TAG_W-1:0] l2_tag_t;

endpackage

// File: rtl/l2_cache_meta_walker_if.sv
// Request/grant, ECC-error and metadata write-port bundle of the L2 metadata walker.
interface l2_cache_meta_walker_if;
  import l2_cache_meta_walker_pkg::*;

  logic                 walk_start;
  logic                 walk_busy;
  logic                 walk_done;
  logic                 wk_request;
  logic                 wk_grant;
  logic                 hamming_error;
  l2_set_idx_t          hamming_set_idx;
  logic                 hamming_overflow;
  logic [L2_WAYS-1:0]   wk_update_tag_en;
  l2_set_idx_t          wk_update_tag_set;
  logic                 wk_update_tag_valid;
  l2_tag_t              wk_update_tag_value;
  logic [L2_WAYS-1:0]   wk_update_dirty_en;
  l2_set_idx_t          wk_update_dirty_set;
  logic                 wk_update_dirty_value;

  modport master (
    output walk_start, wk_grant, hamming_error, hamming_set_idx,
    input  walk_busy, walk_done, wk_request, hamming_overflow,
           wk_update_tag_en, wk_update_tag_set, wk_update_tag_valid, wk_update_tag_value,
           wk_update_dirty_en, wk_update_dirty_set, wk_update_dirty_value
  );

  modport slave (
    input  walk_start, wk_grant, hamming_error, hamming_set_idx,
    output walk_busy, walk_done, wk_request, hamming_overflow,
           wk_update_tag_en, wk_update_tag_set, wk_update_tag_valid, wk_update_tag_value,
           wk_update_dirty_en, wk_update_dirty_set, wk_update_dirty_value
  );

endinterface

// File: rtl/l2_cache_meta_walker_err_fifo.sv
// l2_meta_err_fifo: small FIFO of ECC-error set indices; a push into a full queue
// is dropped and reported on o_drop unless a pop frees a slot in the same cycle.
module l2_meta_err_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wr_ptr;
  logic [PTRW-1:0]  r_rd_ptr;
  logic [PTRW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & ((r_count != (PTRW+1)'(DEPTH)) | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTRW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTRW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/l2_cache_meta_walker.sv
// Walks every L2 set invalidating tag and dirty metadata; ECC-error set invalidation
// queue is built only when L2_META_WALKER_HAMMING_QUEUE_EN is defined.
module l2_cache_meta_walker
  import l2_cache_meta_walker_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  l2_cache_meta_walker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} walk_state_t;

  walk_state_t r_state;
  l2_set_idx_t r_set_cnt;
  logic        w_q_valid;
  l2_set_idx_t w_q_head;
  logic        w_overflow;
  logic        w_request;
  logic        w_grant;
  logic        w_err_sel;
  logic        w_walk_sel;
  logic        w_walk_last;

`ifdef L2_META_WALKER_HAMMING_QUEUE_EN
  logic w_q_empty;
  logic w_q_drop;
  logic r_overflow;

  l2_meta_err_fifo #(
    .WIDTH (L2_SET_W),
    .DEPTH (ERR_QUEUE_DEPTH)
  ) u_err_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.hamming_error),
    .i_data  (bus.hamming_set_idx),
    .i_pop   (w_err_sel),
    .o_data  (w_q_head),
    .o_empty (w_q_empty),
    .o_drop  (w_q_drop)
  );

  assign w_q_valid  = ~w_q_empty;
  assign w_overflow = r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_overflow <= 1'b0;
    else if (w_q_drop) r_overflow <= 1'b1;
  end
`else
  logic w_unused;

  assign w_unused   = ^{bus.hamming_error, bus.hamming_set_idx};
  assign w_q_valid  = 1'b0;
  assign w_q_head   = '0;
  assign w_overflow = 1'b0;
`endif

  // Queued error invalidates win the port over the sequential walk.
  assign w_request   = (r_state == WALK) | w_q_valid;
  assign w_grant     = bus.wk_grant & w_request;
  assign w_err_sel   = w_grant & w_q_valid;
  assign w_walk_sel  = w_grant & ~w_q_valid & (r_state == WALK);
  assign w_walk_last = (r_set_cnt == l2_set_idx_t'(L2_SETS-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_set_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.walk_start) begin
            r_state   <= WALK;
            r_set_cnt <= '0;
          end
        end
        WALK: begin
          if (w_walk_sel) begin
            r_set_cnt <= r_set_cnt + 1'b1;
            if (w_walk_last) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.walk_busy             = (r_state == WALK);
  assign bus.walk_done             = (r_state == DONE);
  assign bus.wk_request            = w_request;
  assign bus.hamming_overflow      = w_overflow;
  assign bus.wk_update_tag_en      = {L2_WAYS{w_err_sel | w_walk_sel}};
  assign bus.wk_update_tag_set     = w_q_valid ? w_q_head : r_set_cnt;
  assign bus.wk_update_tag_valid   = 1'b0;
  assign bus.wk_update_tag_value   = '0;
  assign bus.wk_update_dirty_en    = {L2_WAYS{w_walk_sel}};
  assign bus.wk_update_dirty_set   = r_set_cnt;
  assign bus.wk_update_dirty_value = 1'b0;

endmodule

// File: tb/tb_l2_cache_meta_walker.sv
// Scoreboard bench for l2_cache_meta_walker; queue scenarios run only when
// L2_META_WALKER_HAMMING_QUEUE_EN is defined, the reset/ignore scenario otherwise.
module tb_l2_cache_meta_walker;
  import l2_cache_meta_walker_pkg::*;

  typedef struct {
    l2_set_idx_t set;
    logic        dirty;
  } exp_wr_t;

  localparam logic [L2_WAYS-1:0] ALL_WAYS = '1;

  logic    clk    = 1'b0;
  logic    reset  = 1'b0;
  int      cyc    = 0;
  int      checks = 0;
  int      errors = 0;
  int      s;
  exp_wr_t expWr[$];
  int      expDone[$];
  exp_wr_t monE;
  int      monDone;

  l2_cache_meta_walker_if bus();

  l2_cache_meta_walker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic grant, input logic herr,
                               input l2_set_idx_t hset);
    @(posedge clk);
    #1;
    bus.walk_start      = start;
    bus.wk_grant        = grant;
    bus.hamming_error   = herr;
    bus.hamming_set_idx = hset;
  endtask

  task automatic pushWalk(input int first, input int last);
    for (int k = first; k <= last; k++) expWr.push_back('{l2_set_idx_t'(k), 1'b1});
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},     32'(bus.walk_busy),          32'd0);
    checkOutput({tag, "_done"},     32'(bus.walk_done),          32'd0);
    checkOutput({tag, "_request"},  32'(bus.wk_request),         32'd0);
    checkOutput({tag, "_overflow"}, 32'(bus.hamming_overflow),   32'd0);
    checkOutput({tag, "_tag_en"},   32'(bus.wk_update_tag_en),   32'd0);
    checkOutput({tag, "_dirty_en"}, 32'(bus.wk_update_dirty_en), 32'd0);
  endtask

  // Monitor: every presented write or done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.wk_update_tag_en != '0 || bus.wk_update_dirty_en != '0) begin
        checkOutput("wr_granted", 32'(bus.wk_grant), 32'd1);
        if (expWr.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL wr_unexpected at cycle %0d: write to set 0x%0h, expected no write",
                   cyc, bus.wk_update_tag_set);
        end else begin
          monE = expWr.pop_front();
          checkOutput("wr_set",       32'(bus.wk_update_tag_set),   32'(monE.set));
          checkOutput("wr_tag_en",    32'(bus.wk_update_tag_en),    32'(ALL_WAYS));
          checkOutput("wr_tag_valid", 32'(bus.wk_update_tag_valid), 32'd0);
          checkOutput("wr_tag_value", 32'(bus.wk_update_tag_value), 32'd0);
          checkOutput("wr_dirty_en",  32'(bus.wk_update_dirty_en),
                      monE.dirty ? 32'(ALL_WAYS) : 32'd0);
          if (monE.dirty) begin
            checkOutput("wr_dirty_set",   32'(bus.wk_update_dirty_set),   32'(monE.set));
            checkOutput("wr_dirty_value", 32'(bus.wk_update_dirty_value), 32'd0);
          end
        end
      end
      if (bus.walk_done) begin
        if (expDone.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL done_unexpected at cycle %0d: walk_done=1, expected 0", cyc);
        end else begin
          monDone = expDone.pop_front();
          checkOutput("done_cycle", 32'(cyc), 32'(monDone));
        end
      end
    end
  end

  initial begin
    bus.walk_start      = 1'b0;
    bus.wk_grant        = 1'b0;
    bus.hamming_error   = 1'b0;
    bus.hamming_set_idx = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    // Full walk with grant held; second start at cycle 100 must be ignored
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    s = cyc;
    pushWalk(0, L2_SETS-1);
    expDone.push_back(s + L2_SETS + 1);
    @(negedge clk);
    checkOutput("busy_at_start", 32'(bus.walk_busy), 32'd0);
    for (int i = 1; i <= 262; i++) begin
      applyStimulus(i == 100, 1'b1, 1'b0, '0);
      if (i == 1 || i == 256 || i == 258) begin
        @(negedge clk);
        checkOutput("walk1_busy", 32'(bus.walk_busy), (i == 258) ? 32'd0 : 32'd1);
      end
    end
    checkOutput("walk1_writes_left", 32'(expWr.size()),   32'd0);
    checkOutput("walk1_done_left",   32'(expDone.size()), 32'd0);

    // Alternating grant: writes only in granted cycles, completion at 512
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    s = cyc;
    pushWalk(0, L2_SETS-1);
    expDone.push_back(s + 2 * L2_SETS);
    for (int i = 1; i <= 515; i++) applyStimulus(1'b0, (i % 2) == 1, 1'b0, '0);
    checkOutput("walk2_writes_left", 32'(expWr.size()),   32'd0);
    checkOutput("walk2_done_left",   32'(expDone.size()), 32'd0);

`ifdef L2_META_WALKER_HAMMING_QUEUE_EN
    // Error injected as the counter reaches 0x40 preempts the walk, which then resumes
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    s = cyc;
    pushWalk(0, 'h3F);
    expWr.push_back('{8'h12, 1'b0});
    pushWalk('h40, L2_SETS-1);
    expDone.push_back(s + L2_SETS + 2);
    for (int i = 1; i <= 262; i++) applyStimulus(1'b0, 1'b1, i == 64, 8'h12);
    checkOutput("walk3_writes_left", 32'(expWr.size()),   32'd0);
    checkOutput("walk3_done_left",   32'(expDone.size()), 32'd0);

    // A push into an empty queue is not serviced in the same cycle
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
    @(negedge clk);
    checkOutput("push_empty_tag_en",  32'(bus.wk_update_tag_en), 32'd0);
    checkOutput("push_empty_request", 32'(bus.wk_request),       32'd0);
    expWr.push_back('{8'h33, 1'b0});
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Push and pop in the same cycle while full succeeds without overflow
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, l2_set_idx_t'(8'hA1 + i));
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 5; i++) expWr.push_back('{l2_set_idx_t'(8'hA1 + i), 1'b0});
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("full_pushpop_overflow", 32'(bus.hamming_overflow), 32'd0);
    checkOutput("full_pushpop_left",     32'(expWr.size()),         32'd0);

    // Five errors without grant: fifth is dropped and overflow sticks
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, l2_set_idx_t'(8'hB1 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkOutput("ovf_flag",    32'(bus.hamming_overflow), 32'd1);
    checkOutput("ovf_request", 32'(bus.wk_request),       32'd1);
    for (int i = 0; i < 4; i++) expWr.push_back('{l2_set_idx_t'(8'hB1 + i), 1'b0});
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("ovf_sticky",   32'(bus.hamming_overflow), 32'd1);
    checkOutput("ovf_drained",  32'(expWr.size()),         32'd0);
    checkOutput("ovf_request0", 32'(bus.wk_request),       32'd0);
`endif

    // Reset mid-walk at counter 0x80 abandons the walk without a done pulse
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    pushWalk(0, 'h7F);
    for (int i = 1; i <= 128; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    reset = 1'b0;
    #1;
    checkIdleOutputs("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("midreset_writes_left", 32'(expWr.size()), 32'd0);

`ifdef L2_META_WALKER_HAMMING_QUEUE_EN
    // Queued errors are dropped by reset
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, l2_set_idx_t'(8'hC1 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      checkOutput("q_reset_request", 32'(bus.wk_request), 32'd0);
    end
`else
    // Without the queue, ECC errors are ignored entirely
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, l2_set_idx_t'(8'h55 + i));
      @(negedge clk);
      checkOutput("noq_request",  32'(bus.wk_request),       32'd0);
      checkOutput("noq_overflow", 32'(bus.hamming_overflow), 32'd0);
    end
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("final");
    checkOutput("final_writes_left", 32'(expWr.size()),   32'd0);
    checkOutput("final_done_left",   32'(expDone.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_cache_meta_walker.md
L2_CACHE_META_WALKER -- requirements
Module: l2_cache_meta_walker

Interface
REQ-001 The block SHALL have these ports: clk, in, 1, the single clock; all state updates on its rising edge.
REQ-002 reset, in, 1: asynchronous, active-low; asserted when 0.
REQ-003 walk_start, in, 1: request to invalidate all L2 tag/dirty metadata.
REQ-004 walk_busy, out, 1: a full walk is in progress.
REQ-005 walk_done, out, 1: one-cycle pulse on walk completion.
REQ-006 wk_request, out, 1: the walker has a metadata write pending.
REQ-007 wk_grant, in, 1: the walker owns the tag-stage update port this cycle.
REQ-008 hamming_error, in, 1 / hamming_set_idx, in, l2_set_idx_t: a set with an ECC error, to be invalidated.
REQ-009 hamming_overflow, out, 1: sticky flag, set when an error is dropped.
REQ-010 wk_update_tag_en, out, [L2_WAYS] / wk_update_tag_set, out, l2_set_idx_t / wk_update_tag_valid, out, 1 / wk_update_tag_value, out, l2_tag_t: tag write port.
REQ-011 wk_update_dirty_en, out, [L2_WAYS] / wk_update_dirty_set, out, l2_set_idx_t / wk_update_dirty_value, out, 1: dirty write port.

Function
REQ-012 States SHALL be IDLE, WALK and DONE; a set counter SHALL be log2(L2_SETS) bits wide.
REQ-013 IDLE->WALK SHALL occur on the edge that samples walk_start=1, with the counter cleared to 0.
REQ-014 In WALK, walk_busy=1; walk_start SHALL be ignored while busy.
REQ-015 wk_request = (state==WALK) | (error queue non-empty).
REQ-016 Every update enable SHALL be combinationally gated by wk_grant & wk_request; with no grant, all enables are 0 and no state advances.
REQ-017 Priority: a non-empty error queue SHALL be serviced before the walk.
  - On grant, set = queue head; all tag_en bits = 1; tag_valid = 0; dirty_en = 0; the head is popped.
REQ-018 Walk grant (queue empty): set = counter; all tag_en and dirty_en bits = 1; tag_valid = 0; tag_value = 0; dirty_value = 0; counter increments.
REQ-019 A granted walk write at counter = L2_SETS-1 SHALL move WALK->DONE; the counter wraps to 0.
REQ-020 DONE SHALL assert walk_done for exactly one cycle, then return to IDLE.
REQ-021 Walk latency with grant held at 1 and an empty queue: walk_busy rises 1 cycle after start; walk_done pulses L2_SETS+1 cycles after start.
REQ-022 Error queue: FIFO, depth 4.
  - Push on hamming_error.
  - Push while full SHALL drop the entry and set hamming_overflow.
  - Push and pop in the same cycle while full SHALL succeed, with no overflow.
  - Push while empty SHALL NOT be serviced in the same cycle.
REQ-023 hamming_overflow SHALL clear only on reset.

Reset
REQ-024 While reset=0: state=IDLE, counter=0, queue empty, walk_busy=0, walk_done=0, wk_request=0, hamming_overflow=0, all enables=0.
REQ-025 Reset asserted mid-walk SHALL abandon the walk without a walk_done pulse and drop all queued errors.

Configuration
REQ-026 The macro L2_META_WALKER_HAMMING_QUEUE_EN SHALL control the error queue.
  - Defined: the error queue and the REQ-017/REQ-022 behaviour are present.
  - Undefined: no queue; hamming_error and hamming_set_idx are ignored; hamming_overflow is tied to 0; wk_request = (state==WALK).

Structure
REQ-027 L2_WAYS, L2_SETS, l2_set_idx_t and l2_tag_t SHALL come from the shared defines package; the walker state enum SHALL be local.
REQ-028 The error queue SHALL be one sub-module, l2_meta_err_fifo, with parameters WIDTH and DEPTH.

Verification
REQ-029 L2_SETS=256, grant held 1, walk_start pulsed at cycle 0 -> 256 writes with sets 0..255 in order; all enables set; walk_done pulses at cycle 257 only.
REQ-030 Grant toggled 1,0,1,0 during a walk -> writes only in granted cycles; the set sequence has no gaps or repeats; completion takes 512 cycles.
REQ-031 hamming_error with set 0x12, injected mid-walk at counter 0x40 -> the next granted write is set 0x12 with tag_en all 1 and dirty_en 0; the walk then resumes at 0x40.
REQ-032 Five errors in consecutive cycles with grant=0 -> 4 errors queued and hamming_overflow=1; after grant, exactly 4 invalidates in FIFO order.
REQ-033 walk_start re-pulsed at cycle 100 of a walk -> ignored; exactly one walk_done.
REQ-034 reset driven to 0 at counter 0x80, then released, with the macro undefined -> outputs return to reset values; no walk_done; hamming_error is ignored and wk_request stays 0.
